filter_output_arbiter: RTL and testbench

FILTER_OUTPUT_ARBITER -- requirements
Module: filter_output_arbiter

---
 rtl/filter_arb_pkg.sv | 14 +
 rtl/filter_output_arbiter_rr_pick.sv | 32 +++
 rtl/filter_output_arbiter.sv | 108 ++++++++++
 tb/tb_filter_output_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_arb_pkg.sv
// Shared definitions for the filter output arbiter: defaults and FSM state encoding.
// Latency: n/a.  Backpressure: n/a.
package filter_arb_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCEPT = 2'd1;
    localparam state_t ST_SEND   = 2'd2;

endpackage

// File: rtl/filter_output_arbiter_rr_pick.sv
// Round-robin pick: first set bit of req at or after ptr, wrapping modulo N.
// Latency: combinational.  Backpressure: none.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          vld
);

    logic [IW:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        vld = 1'b0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(N)) begin
                pos = pos - (IW + 1)'(N);
            end
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_output_arbiter.sv
// Round-robin arbiter merging N_REQ filter streams into one sink via a one-word buffer; optional out_tag with FILTER_ARB_TAG_EN.
// Latency: stb sampled -> in_ack next cycle -> out_stb the cycle after (2 cycles min).
// Backpressure: out_ack low holds the buffered word; no in_ack is raised while out_stb is high.
module filter_output_arbiter
    import filter_arb_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BURST  = 1,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_stb,
    output logic [N_REQ-1:0]        in_ack,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_stb,
    input  logic                    out_ack,
`ifdef FILTER_ARB_TAG_EN
    output logic [IW-1:0]           out_tag,
`endif
    output logic                    busy
);

    state_t        state;
    logic [IW-1:0] grant;
    logic [IW-1:0] rr_ptr;
    logic [3:0]    burst_cnt;
    logic [IW-1:0] pick_idx;
    logic          pick_vld;
    logic [IW-1:0] next_ptr;
    logic          burst_more;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req (in_stb),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    assign next_ptr   = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
    assign burst_more = ({1'b0, burst_cnt} + 5'd1) < 5'(BURST);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            in_ack    <= '0;
            out_stb   <= 1'b0;
            out_data  <= '0;
`ifdef FILTER_ARB_TAG_EN
            out_tag   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick_idx;
                        in_ack <= N_REQ'(1) << pick_idx;
                        state  <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    in_ack <= '0;
                    if (in_stb[grant]) begin
                        out_data <= in_data[grant*DATA_W +: DATA_W];
                        out_stb  <= 1'b1;
`ifdef FILTER_ARB_TAG_EN
                        out_tag  <= grant;
`endif
                        state    <= ST_SEND;
                    end else begin
                        // Requester withdrew: give up its turn.
                        rr_ptr    <= next_ptr;
                        burst_cnt <= '0;
                        state     <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (out_ack) begin
                        out_stb <= 1'b0;
                        if (burst_more && in_stb[grant]) begin
                            burst_cnt <= burst_cnt + 4'd1;
                            in_ack    <= N_REQ'(1) << grant;
                            state     <= ST_ACCEPT;
                        end else begin
                            rr_ptr    <= next_ptr;
                            burst_cnt <= '0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    in_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_output_arbiter.sv
// Bench for filter_output_arbiter: two instances (BURST=1 and BURST=3) with a queue scoreboard per sink.
module tb_filter_output_arbiter;

    typedef struct packed {
        logic [1:0]  src;
        logic [31:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [3:0]   stb  [2];
    logic [127:0] dat  [2];
    logic [3:0]   iack [2];
    logic [31:0]  odat [2];
    logic         ostb [2];
    logic         oack [2];
    logic         bsy  [2];
`ifdef FILTER_ARB_TAG_EN
    logic [1:0]   otag [2];
`endif

    int n_checks = 0;
    int n_errors = 0;

    int          cnt_left [2][4];
    int          seq      [2][4];
    logic [31:0] base     [2][4];
    bit          pend     [2][4];
    exp_t        exp_q0[$];
    exp_t        exp_q1[$];

    filter_output_arbiter #(.N_REQ(4), .DATA_W(32), .BURST(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (dat[0]),
        .in_stb   (stb[0]),
        .in_ack   (iack[0]),
        .out_data (odat[0]),
        .out_stb  (ostb[0]),
        .out_ack  (oack[0]),
`ifdef FILTER_ARB_TAG_EN
        .out_tag  (otag[0]),
`endif
        .busy     (bsy[0])
    );

    filter_output_arbiter #(.N_REQ(4), .DATA_W(32), .BURST(3)) u_dut_burst (
        .clk      (clk),
        .rst      (rst),
        .in_data  (dat[1]),
        .in_stb   (stb[1]),
        .in_ack   (iack[1]),
        .out_data (odat[1]),
        .out_stb  (ostb[1]),
        .out_ack  (oack[1]),
`ifdef FILTER_ARB_TAG_EN
        .out_tag  (otag[1]),
`endif
        .busy     (bsy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic load(input int d, input int i, input int n, input logic [31:0] b);
        base[d][i]     = b;
        seq[d][i]      = 0;
        cnt_left[d][i] = n;
    endtask

    task automatic push(input int d, input int i, input logic [31:0] w);
        exp_t e;
        e.src  = 2'(i);
        e.data = w;
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int d, input string tag);
        logic pending;
        pending = 1'b1;
        for (int c = 0; c < 400 && pending; c++) begin
            tick();
            pending = (qsize(d) != 0) || (stb[d] != 4'd0) || ostb[d] || bsy[d];
        end
        check_eq(tag, 64'(pending), 64'd0);
    endtask

    task automatic wait_ostb(input int d, input string tag);
        for (int c = 0; c < 20 && !ostb[d]; c++) tick();
        check_eq(tag, 64'(ostb[d]), 64'd1);
    endtask

    // Sink monitor and requester models, evaluated on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ostb[d]) check_eq("ack_while_out_stb", 64'(iack[d]), 64'd0);
                if (ostb[d] && oack[d]) begin
                    if (qsize(d) == 0) begin
                        check_eq("sink_extra_word_q_len", 64'd0, 64'd1);
                    end else begin
                        exp_t e;
                        if (d == 0) e = exp_q0.pop_front();
                        else        e = exp_q1.pop_front();
                        check_eq("sink_data", 64'(odat[d]), 64'(e.data));
`ifdef FILTER_ARB_TAG_EN
                        check_eq("sink_tag", 64'(otag[d]), 64'(e.src));
`endif
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (pend[d][i]) begin
                        cnt_left[d][i]--;
                        seq[d][i]++;
                    end
                    stb[d][i]            = (cnt_left[d][i] > 0);
                    dat[d][i*32 +: 32]   = base[d][i] + 32'(seq[d][i]);
                    pend[d][i]           = iack[d][i] && stb[d][i];
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            stb[d]  = '0;
            dat[d]  = '0;
            oack[d] = 1'b1;
            for (int i = 0; i < 4; i++) begin
                load(d, i, 0, 32'h0);
                pend[d][i] = 1'b0;
            end
        end
        #2;
        check_eq("reset_in_ack", 64'(iack[0]), 64'd0);
        check_eq("reset_out_stb", 64'(ostb[0]), 64'd0);
        check_eq("reset_out_data", 64'(odat[0]), 64'd0);
        check_eq("reset_busy", 64'(bsy[0]), 64'd0);
`ifdef FILTER_ARB_TAG_EN
        check_eq("reset_out_tag", 64'(otag[0]), 64'd0);
`endif
        tick();
        tick();
        rst = 1'b0;

        // Fairness on BURST=1 and bursting on BURST=3, run side by side.
        for (int i = 0; i < 4; i++) load(0, i, 2, 32'hA000_0000 | (32'(i) << 16));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) push(0, i, (32'hA000_0000 | (32'(i) << 16)) + 32'(r));
        load(1, 0, 6, 32'hB000_0000);
        load(1, 1, 6, 32'hB001_0000);
        for (int blk = 0; blk < 4; blk++)
            for (int k = 0; k < 3; k++)
                push(1, blk % 2, (32'hB000_0000 | (32'(blk % 2) << 16)) + 32'((blk / 2) * 3 + k));
        wait_drain(0, "fairness_drain");
        wait_drain(1, "burst_drain");

        // Single source latency.
        load(0, 2, 1, 32'h0000_1234);
        push(0, 2, 32'h0000_1234);
        tick();
        check_eq("single_in_ack", 64'(iack[0]), 64'h4);
        check_eq("single_out_stb_early", 64'(ostb[0]), 64'd0);
        check_eq("single_busy", 64'(bsy[0]), 64'd1);
        tick();
        check_eq("single_in_ack_dropped", 64'(iack[0]), 64'd0);
        check_eq("single_out_stb", 64'(ostb[0]), 64'd1);
        check_eq("single_out_data", 64'(odat[0]), 64'h1234);
        tick();
        check_eq("single_out_stb_done", 64'(ostb[0]), 64'd0);
        check_eq("single_busy_done", 64'(bsy[0]), 64'd0);

        // Back-pressure: sink stalls for ten cycles.
        oack[0] = 1'b0;
        load(0, 0, 2, 32'hC000_0000);
        push(0, 0, 32'hC000_0000);
        push(0, 0, 32'hC000_0001);
        wait_ostb(0, "bp_out_stb_seen");
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_out_stb_held", 64'(ostb[0]), 64'd1);
            check_eq("bp_out_data_held", 64'(odat[0]), 64'hC000_0000);
            check_eq("bp_in_ack_low", 64'(iack[0]), 64'd0);
            tick();
        end
        oack[0] = 1'b1;
        wait_drain(0, "bp_drain");

        // Requester 3 withdraws while granted; pointer must wrap to 0.
        load(0, 3, 1, 32'hD003_0000);
        tick();
        check_eq("abandon_in_ack", 64'(iack[0]), 64'h8);
        cnt_left[0][3] = 0;
        tick();
        check_eq("abandon_in_ack_drop", 64'(iack[0]), 64'd0);
        check_eq("abandon_busy", 64'(bsy[0]), 64'd0);
        check_eq("abandon_out_stb", 64'(ostb[0]), 64'd0);
        load(0, 0, 1, 32'hE000_0000);
        load(0, 3, 1, 32'hE003_0000);
        push(0, 0, 32'hE000_0000);
        push(0, 3, 32'hE003_0000);
        wait_drain(0, "abandon_drain");

        // Move the pointer to 3, then reset in the middle of SEND.
        load(0, 2, 1, 32'hF002_0000);
        push(0, 2, 32'hF002_0000);
        wait_drain(0, "pre_reset_drain");
        oack[0] = 1'b0;
        load(0, 1, 1, 32'hF001_0000);
        wait_ostb(0, "reset_send_seen");
        #3;
        rst = 1'b1;
        #1;
        check_eq("midreset_out_stb", 64'(ostb[0]), 64'd0);
        check_eq("midreset_out_data", 64'(odat[0]), 64'd0);
        check_eq("midreset_in_ack", 64'(iack[0]), 64'd0);
        check_eq("midreset_busy", 64'(bsy[0]), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        oack[0] = 1'b1;
        load(0, 0, 1, 32'h9000_0000);
        load(0, 3, 1, 32'h9003_0000);
        push(0, 0, 32'h9000_0000);
        push(0, 3, 32'h9003_0000);
        wait_drain(0, "post_reset_drain");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
